// File: rtl/pci_target_mem_pkg.sv
// pci_target_mem_pkg: shared bus command codes, config offsets and
// FSM encoding for the PCI memory target.
package pci_target_mem_pkg;

    localparam logic [3:0] CMD_MEM_RD = 4'h6;
    localparam logic [3:0] CMD_MEM_WR = 4'h7;
    localparam logic [3:0] CMD_CFG_RD = 4'hA;
    localparam logic [3:0] CMD_CFG_WR = 4'hB;

    // config register numbers (dword offset = byte offset / 4)
    localparam logic [5:0] CFG_ID    = 6'h00;
    localparam logic [5:0] CFG_CMD   = 6'h01;
    localparam logic [5:0] CFG_CLASS = 6'h02;
    localparam logic [5:0] CFG_BAR0  = 6'h04;

    localparam int MEM_WORDS = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_TURN,
        ST_DATA,
        ST_BACKOFF
    } state_t;

    // replace the bytes whose active-low enable is asserted
    function automatic logic [31:0] be_merge(
        input logic [31:0] old_w,
        input logic [31:0] new_w,
        input logic [3:0]  be_n
    );
        logic [31:0] r;
        r = old_w;
        for (int i = 0; i < 4; i++)
            if (!be_n[i]) r[8*i +: 8] = new_w[8*i +: 8];
        return r;
    endfunction

endpackage

// File: rtl/pci_target_cfg.sv
// pci_target_cfg: type-0 config header registers (COMMAND bit 1 and
// BAR0) plus the config read mux.
module pci_target_cfg
    import pci_target_mem_pkg::*;
#(
    parameter logic [15:0] VENDOR_ID = 16'h1234,
    parameter logic [15:0] DEVICE_ID = 16'h5678,
    parameter logic [31:0] CLASS_REV = 32'hFF000001
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [5:0]  offset,
    input  logic [3:0]  be_n,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        mem_en,
    output logic [31:6] bar0
);

    logic unused_bits;
    assign unused_bits = ^{wdata[5:2], wdata[0]};

    // writable bits, each byte gated by its own enable
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_en <= 1'b0;
            bar0   <= '0;
        end else if (we) begin
            case (offset)
                CFG_CMD: begin
                    if (!be_n[0]) mem_en <= wdata[1];
                end
                CFG_BAR0: begin
                    if (!be_n[3]) bar0[31:24] <= wdata[31:24];
                    if (!be_n[2]) bar0[23:16] <= wdata[23:16];
                    if (!be_n[1]) bar0[15:8]  <= wdata[15:8];
                    if (!be_n[0]) bar0[7:6]   <= wdata[7:6];
                end
                default: ;
            endcase
        end
    end

    // read mux; unimplemented offsets return zero
    always_comb begin
        rdata = '0;
        case (offset)
            CFG_ID:    rdata = {DEVICE_ID, VENDOR_ID};
            CFG_CMD:   rdata = {30'b0, mem_en, 1'b0};
            CFG_CLASS: rdata = CLASS_REV;
            CFG_BAR0:  rdata = {bar0, 6'b0};
            default:   rdata = '0;
        endcase
    end

endmodule

// File: rtl/pci_target_mem.sv
// pci_target_mem: single-data-phase PCI target with a 16-word memory
// window behind BAR0; every transfer is a disconnect-with-data.
module pci_target_mem
    import pci_target_mem_pkg::*;
#(
    parameter logic [15:0] VENDOR_ID = 16'h1234,
    parameter logic [15:0] DEVICE_ID = 16'h5678,
    parameter logic [31:0] CLASS_REV = 32'hFF000001
) (
    input  logic        PCI_CLK,
    input  logic        RESET,
    input  logic        IDSEL,
    input  logic        FRAME_n,
    input  logic        IRDY_n,
    input  logic [3:0]  C_BE,
    inout  wire  [31:0] AD,
    inout  wire         PAR,
    inout  wire         DEVSEL_n,
    inout  wire         TRDY_n,
    inout  wire         STOP_n
);

    state_t      state;
    logic        prev_idle;
    logic        is_wr;
    logic        is_cfg;
    logic [5:0]  cfg_off;
    logic [3:0]  word;
    logic [31:0] ad_out;
    logic        ad_oe;
    logic        par_out;
    logic        par_oe;
    logic        devsel_out;
    logic        devsel_oe;
    logic        trdy_out;
    logic        stop_out;
    logic        ts_oe;

    logic [31:0] mem [MEM_WORDS];
    logic [31:0] cfg_rdata;
    logic        mem_en;
    logic [31:6] bar0;

    logic addr_phase;
    logic cfg_hit;
    logic mem_hit;
    logic xfer;
    logic cfg_we;
    logic mem_we;

    assign addr_phase = !FRAME_n && prev_idle;
    assign cfg_hit = (C_BE == CMD_CFG_RD || C_BE == CMD_CFG_WR)
                   && IDSEL && AD[1:0] == 2'b00;
    assign mem_hit = (C_BE == CMD_MEM_RD || C_BE == CMD_MEM_WR)
                   && mem_en && AD[31:6] == bar0;
    assign xfer   = state == ST_DATA && !IRDY_n;
    assign cfg_we = xfer && is_wr && is_cfg;
    assign mem_we = xfer && is_wr && !is_cfg && !RESET;

    pci_target_cfg #(
        .VENDOR_ID (VENDOR_ID),
        .DEVICE_ID (DEVICE_ID),
        .CLASS_REV (CLASS_REV)
    ) u_cfg (
        .clk    (PCI_CLK),
        .rst    (RESET),
        .we     (cfg_we),
        .offset (cfg_off),
        .be_n   (C_BE),
        .wdata  (AD),
        .rdata  (cfg_rdata),
        .mem_en (mem_en),
        .bar0   (bar0)
    );

    // memory array is deliberately never reset
    always_ff @(posedge PCI_CLK) begin
        if (mem_we) mem[word] <= be_merge(mem[word], AD, C_BE);
    end

    // target FSM with registered pad values and enables
    always_ff @(posedge PCI_CLK or posedge RESET) begin
        if (RESET) begin
            state      <= ST_IDLE;
            prev_idle  <= 1'b1;
            is_wr      <= 1'b0;
            is_cfg     <= 1'b0;
            cfg_off    <= '0;
            word       <= '0;
            ad_out     <= '0;
            ad_oe      <= 1'b0;
            par_out    <= 1'b0;
            par_oe     <= 1'b0;
            devsel_out <= 1'b1;
            devsel_oe  <= 1'b0;
            trdy_out   <= 1'b1;
            stop_out   <= 1'b1;
            ts_oe      <= 1'b0;
        end else begin
            prev_idle <= FRAME_n && IRDY_n;
            par_oe    <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (addr_phase && (cfg_hit || mem_hit)) begin
                        is_wr      <= C_BE[0];
                        is_cfg     <= cfg_hit;
                        cfg_off    <= AD[7:2];
                        word       <= AD[5:2];
                        devsel_oe  <= 1'b1;
                        devsel_out <= 1'b0;
                        if (C_BE[0]) begin
                            state    <= ST_DATA;
                            ts_oe    <= 1'b1;
                            trdy_out <= 1'b0;
                            stop_out <= 1'b0;
                        end else begin
                            state <= ST_TURN;
                        end
                    end
                end
                ST_TURN: begin
                    state    <= ST_DATA;
                    ad_oe    <= 1'b1;
                    ad_out   <= is_cfg ? cfg_rdata : mem[word];
                    ts_oe    <= 1'b1;
                    trdy_out <= 1'b0;
                    stop_out <= 1'b0;
                end
                ST_DATA: begin
                    if (ad_oe) begin
                        par_oe  <= 1'b1;
                        par_out <= ^{ad_out, C_BE};
                    end
                    if (!IRDY_n) begin
                        state      <= ST_BACKOFF;
                        ad_oe      <= 1'b0;
                        devsel_out <= 1'b1;
                        trdy_out   <= 1'b1;
                        stop_out   <= 1'b1;
                    end
                end
                ST_BACKOFF: begin
                    state     <= ST_IDLE;
                    devsel_oe <= 1'b0;
                    ts_oe     <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign AD       = ad_oe     ? ad_out     : 32'hzzzz_zzzz;
    assign PAR      = par_oe    ? par_out    : 1'bz;
    assign DEVSEL_n = devsel_oe ? devsel_out : 1'bz;
    assign TRDY_n   = ts_oe     ? trdy_out   : 1'bz;
    assign STOP_n   = ts_oe     ? stop_out   : 1'bz;

endmodule

// File: tb/tb_pci_target_mem.sv
// tb_pci_target_mem: bus-master bench with a spec-level model of the
// config header and memory window; directed plus random traffic.
module tb_pci_target_mem;

    logic        clk = 1'b0;
    logic        rst;
    logic        idsel;
    logic        frame_n;
    logic        irdy_n;
    logic [3:0]  c_be;
    logic [31:0] m_ad;
    logic        m_ad_oe;

    tri1 [31:0] ad;
    tri1        par;
    tri1        devsel_n;
    tri1        trdy_n;
    tri1        stop_n;

    assign ad = m_ad_oe ? m_ad : 32'hzzzz_zzzz;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] m_mem [16];
    logic        m_cmd1;
    logic [31:0] m_bar;

    localparam logic [31:0] BASE = 32'h8000_0000;

    always #5 clk = ~clk;

    pci_target_mem dut (
        .PCI_CLK  (clk),
        .RESET    (rst),
        .IDSEL    (idsel),
        .FRAME_n  (frame_n),
        .IRDY_n   (irdy_n),
        .C_BE     (c_be),
        .AD       (ad),
        .PAR      (par),
        .DEVSEL_n (devsel_n),
        .TRDY_n   (trdy_n),
        .STOP_n   (stop_n)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] o,
                                          input logic [31:0] n,
                                          input logic [3:0] be_n);
        logic [31:0] r;
        for (int i = 0; i < 4; i++)
            r[8*i +: 8] = be_n[i] ? o[8*i +: 8] : n[8*i +: 8];
        return r;
    endfunction

    function automatic logic [31:0] cfg_model(input logic [7:0] off);
        case (off)
            8'h00:   return 32'h5678_1234;
            8'h04:   return {30'b0, m_cmd1, 1'b0};
            8'h08:   return 32'hFF00_0001;
            8'h10:   return m_bar;
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_cfg_wr(input logic [7:0] off,
                                input logic [31:0] d,
                                input logic [3:0] be_n);
        if (off == 8'h04 && !be_n[0]) m_cmd1 = d[1];
        if (off == 8'h10) m_bar = merge(m_bar, d, be_n) & 32'hFFFF_FFC0;
    endtask

    task automatic run(input logic [3:0] cmd, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [3:0] be_n,
                       input logic sel, input int wait_n,
                       input bit burst, input string tag);
        bit          is_rd;
        bit          is_cfg;
        bit          hit;
        bit          claimed;
        logic [31:0] exp_rd;
        logic [31:0] rd;
        logic [3:0]  x_cbe;
        int          cyc;
        int          trdy_cyc;
        is_rd  = !cmd[0];
        is_cfg = cmd[3];
        if (is_cfg)
            hit = cmd[3:1] == 3'b101 && sel && addr[1:0] == 2'b00;
        else
            hit = cmd[3:1] == 3'b011 && m_cmd1
                && addr[31:6] == m_bar[31:6];
        exp_rd = is_cfg ? cfg_model(addr[7:0]) : m_mem[addr[5:2]];
        @(negedge clk);
        frame_n = 1'b0; irdy_n = 1'b1; c_be = cmd; idsel = sel;
        m_ad = addr; m_ad_oe = 1'b1;
        @(negedge clk);
        idsel = 1'b0;
        claimed = !devsel_n;
        check({tag, ".devsel"}, 32'(claimed), 32'(hit));
        c_be = be_n;
        if (is_rd) m_ad_oe = 1'b0;
        else m_ad = wd;
        cyc = 0; trdy_cyc = -1; rd = '0;
        if (!claimed) begin
            irdy_n = 1'b0; frame_n = 1'b1;
            repeat (3) begin
                @(negedge clk);
                check({tag, ".nodevsel"}, 32'(devsel_n), 32'(1));
                if (is_rd) check({tag, ".noad"}, ad, 32'hFFFF_FFFF);
            end
        end else begin
            forever begin
                if (cyc >= wait_n) begin
                    irdy_n = 1'b0; frame_n = burst ? 1'b0 : 1'b1;
                end
                if (trdy_cyc < 0 && !trdy_n) trdy_cyc = cyc;
                if (!trdy_n && !irdy_n) break;
                if (cyc > 24) begin
                    check({tag, ".trdy_timeout"}, 32'(trdy_n), 32'(0));
                    break;
                end
                @(negedge clk);
                cyc++;
            end
            check({tag, ".trdy_lat"}, 32'(trdy_cyc), is_rd ? 32'(1) : 32'(0));
            check({tag, ".stop"}, 32'(stop_n), 32'(0));
            rd = ad; x_cbe = c_be;
            @(negedge clk);
            if (is_rd) begin
                check({tag, ".data"}, rd, exp_rd);
                check({tag, ".par"}, 32'(par), 32'(^{rd, x_cbe}));
                check({tag, ".adrel"}, ad, 32'hFFFF_FFFF);
            end
            check({tag, ".backoff"}, 32'({devsel_n, trdy_n, stop_n}), 32'(7));
            if (burst) begin
                m_ad = ~wd; irdy_n = 1'b0; frame_n = 1'b1;
            end else begin
                frame_n = 1'b1; irdy_n = 1'b1; m_ad_oe = 1'b0;
            end
        end
        if (hit && !is_rd) begin
            if (is_cfg) model_cfg_wr(addr[7:0], wd, be_n);
            else m_mem[addr[5:2]] = merge(m_mem[addr[5:2]], wd, be_n);
        end
        @(negedge clk);
        frame_n = 1'b1; irdy_n = 1'b1; m_ad_oe = 1'b0; c_be = 4'h0;
        check({tag, ".idle"}, 32'({devsel_n, trdy_n, stop_n}), 32'(7));
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0]  dead_offs [6];
        logic [31:0] d;
        logic [3:0]  b;
        int          w;
        int          k;
        int          wt;
        dead_offs = '{8'h00, 8'h08, 8'h0C, 8'h14, 8'h18, 8'h1C};
        rst = 1'b1; idsel = 1'b0; frame_n = 1'b1; irdy_n = 1'b1;
        c_be = 4'h0; m_ad = '0; m_ad_oe = 1'b0;
        m_cmd1 = 1'b0; m_bar = '0;
        repeat (3) @(negedge clk);
        check("rst.ctl", 32'({devsel_n, trdy_n, stop_n}), 32'(7));
        check("rst.ad", ad, 32'hFFFF_FFFF);
        rst = 1'b0;
        @(negedge clk);

        run(4'hA, 32'h00, 0, 4'h0, 1, 0, 0, "cfg_id");
        run(4'hA, 32'h04, 0, 4'h0, 1, 0, 0, "cfg_cmd0");
        run(4'hA, 32'h10, 0, 4'h0, 1, 1, 0, "cfg_bar0");
        run(4'hA, 32'h08, 0, 4'h0, 1, 0, 0, "cfg_class");
        run(4'hA, 32'h0C, 0, 4'h0, 1, 0, 0, "cfg_unimpl");
        run(4'hA, 32'h00, 0, 4'h0, 0, 0, 0, "cfg_nosel");
        run(4'hB, 32'h10, 32'hFFFF_FFFF, 4'h0, 1, 0, 0, "bar_wr1");
        run(4'hA, 32'h10, 0, 4'h0, 1, 0, 0, "bar_rd1");
        run(4'hB, 32'h10, 32'h0, 4'b1110, 1, 1, 0, "bar_wr_be");
        run(4'hA, 32'h10, 0, 4'h0, 1, 0, 0, "bar_rd_be");
        run(4'hB, 32'h10, 32'h8000_0000, 4'h0, 1, 0, 0, "bar_wr2");
        run(4'hB, 32'h04, 32'h0000_0002, 4'h0, 1, 0, 0, "cmd_wr");
        run(4'hA, 32'h04, 0, 4'h0, 1, 0, 0, "cmd_rd");

        run(4'h7, BASE + 8, 32'hDEAD_BEEF, 4'b0000, 0, 0, 0, "mw_full");
        run(4'h7, BASE + 8, 32'h0000_CAFE, 4'b1100, 0, 2, 0, "mw_half");
        run(4'h6, BASE + 8, 0, 4'b0000, 0, 0, 0, "mr_merge");
        run(4'h6, BASE + 32'h40, 0, 4'h0, 0, 0, 0, "mr_outside");

        run(4'h7, BASE + 32'h14, 32'hA5A5_A5A5, 4'h0, 0, 0, 0, "mw_next");
        run(4'h7, BASE + 32'h10, 32'h1111_1111, 4'h0, 0, 0, 1, "burst");
        run(4'h6, BASE + 32'h10, 0, 4'h0, 0, 0, 0, "burst_w0");
        run(4'h6, BASE + 32'h14, 0, 4'h0, 0, 1, 0, "burst_w1");

        run(4'hB, 32'h04, 32'h0, 4'h0, 1, 0, 0, "cmd_off");
        run(4'h6, BASE + 8, 0, 4'h0, 0, 0, 0, "mr_disabled");
        run(4'hB, 32'h04, 32'h2, 4'h0, 1, 0, 0, "cmd_on");

        for (int i = 0; i < 16; i++)
            run(4'h7, BASE + 32'(i * 4), $urandom, 4'h0, 0, 0, 0, "fill");

        for (int i = 0; i < 40; i++) begin
            k  = $urandom_range(0, 5);
            w  = $urandom_range(0, 15);
            d  = $urandom;
            b  = 4'($urandom_range(0, 15));
            wt = $urandom_range(0, 2);
            case (k)
                0, 1: run(4'h7, BASE + 32'(w * 4), d, b, 0, wt, 0, "rnd_mw");
                2: run(4'h6, BASE + 32'(w * 4), 0, b, 0, wt, 0, "rnd_mr");
                3: run(4'hA, 32'($urandom_range(0, 7) * 4), 0, b,
                       1'($urandom_range(0, 3) != 0), wt, 0, "rnd_cr");
                4: run(4'hB, {24'h0, dead_offs[w % 6]}, d, b, 1, wt, 0,
                       "rnd_cw");
                default: run(4'h6, d & 32'hFFFF_FFFC, 0, b, 0, wt, 0,
                             "rnd_addr");
            endcase
        end
        run(4'hA, 32'h10, 0, 4'h0, 1, 0, 0, "bar_after_rnd");

        @(negedge clk);
        frame_n = 1'b0; irdy_n = 1'b1; c_be = 4'h7;
        m_ad = BASE + 8; m_ad_oe = 1'b1;
        @(negedge clk);
        c_be = 4'h0; m_ad = 32'h0BAD_F00D;
        check("rst_mid.trdy", 32'(trdy_n), 32'(0));
        irdy_n = 1'b0; frame_n = 1'b1;
        #1 rst = 1'b1;
        #1;
        check("rst_mid.async", 32'({devsel_n, trdy_n, stop_n}), 32'(7));
        @(negedge clk);
        frame_n = 1'b1; irdy_n = 1'b1; m_ad_oe = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        m_cmd1 = 1'b0; m_bar = '0;
        @(negedge clk);
        run(4'hA, 32'h04, 0, 4'h0, 1, 0, 0, "post_rst_cmd");
        run(4'hA, 32'h10, 0, 4'h0, 1, 0, 0, "post_rst_bar");
        run(4'h6, BASE + 8, 0, 4'h0, 0, 0, 0, "post_rst_miss");
        run(4'hB, 32'h10, BASE, 4'h0, 1, 0, 0, "re_bar");
        run(4'hB, 32'h04, 32'h2, 4'h0, 1, 0, 0, "re_cmd");
        run(4'h6, BASE + 8, 0, 4'h0, 0, 0, 0, "post_rst_word");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
